// File: rtl/onehot_dec_32b.sv
// Index-to-one-hot decoder with a scatter accumulator: direct indices are emitted
// one cycle later, accumulated indices are OR-ed into a held vector and emitted on flush.
module onehot_dec_32b #(
  parameter int W  = 32,
  parameter int IW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_val,
  input  logic [IW-1:0] in_idx,
  input  logic          acc,
  input  logic          flush,
  output logic [W-1:0]  out_vec,
  output logic          out_val,
  output logic [IW-1:0] cnt,
  output logic          err,
  output logic          busy
);
  localparam int LW = IW - 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  out_vec_q, out_vec_d;
  logic          out_val_q, out_val_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          good, bad;
  logic [W-1:0]  dec;

  // Index MSB set means in_idx >= W since W is a power of two.
  assign bad  = in_val &  in_idx[IW-1];
  assign good = in_val & ~in_idx[IW-1];

  for (genvar i = 0; i < W; i++) begin : g_dec
    assign dec[i] = good & (in_idx[LW-1:0] == LW'(i));
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_vec_d = out_vec_q;
    out_val_d = 1'b0;
    err_d     = bad;
    if (flush) begin
      // Same-cycle index merges into the flushed vector regardless of acc.
      out_vec_d = acc_q | dec;
      out_val_d = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
      state_d   = IDLE;
    end else if (good && acc) begin
      acc_d   = acc_q | dec;
      state_d = HOLD;
      if (|(dec & ~acc_q)) cnt_d = cnt_q + IW'(1);
    end else if (good) begin
      out_vec_d = dec;
      out_val_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_vec_q <= '0;
      out_val_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_vec_q <= out_vec_d;
      out_val_q <= out_val_d;
      err_q     <= err_d;
    end
  end

  assign out_vec = out_vec_q;
  assign out_val = out_val_q;
  assign cnt     = cnt_q;
  assign err     = err_q;
  assign busy    = (state_q == HOLD);
endmodule
